// File: rtl/reset_pulse_generator.sv
// Fixed-width reset pulse toward an external target, followed by a guard interval.
// A request during the guard interval is remembered and chains a second hold directly.
module reset_pulse_generator #(
    parameter int HOLD_COUNT  = 65_536,
    parameter int GUARD_COUNT = 65_536,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic req,
    output logic out_rst,
    output logic busy,
    output logic done
);

    localparam int MAX_COUNT = (HOLD_COUNT > GUARD_COUNT) ? HOLD_COUNT : GUARD_COUNT;
    localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_COUNT - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_COUNT - 1);
    localparam logic          LVL_ASSERT = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic          LVL_IDLE   = ~LVL_ASSERT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pending, pending_nxt;
    logic          done_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                pending_nxt = 1'b0;
                if (req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                // Requests here are dropped: a running hold is never stretched.
                if (cnt == '0) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GUARD: begin
                if (cnt == '0) begin
                    // A request on the final guard edge is served like a pending one.
                    if (pending || req) begin
                        state_nxt   = HOLD;
                        cnt_nxt     = HOLD_LOAD;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (req) pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so the pin never sees a comb path from req.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            out_rst <= LVL_IDLE;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            done    <= done_nxt;
            busy    <= (state_nxt != IDLE);
            out_rst <= (state_nxt == HOLD) ? LVL_ASSERT : LVL_IDLE;
        end
    end

endmodule

// File: tb/tb_reset_pulse_generator.sv
// Bench for reset_pulse_generator: two instances (4/3 active-low, 1/1 active-high)
// checked every cycle against an edge-timestamp model plus literal scenario tables.
module tb_reset_pulse_generator;

    localparam int H0 = 4;
    localparam int G0 = 3;
    localparam int H1 = 1;
    localparam int G1 = 1;

    logic clk, rst, req0, req1;
    logic out0, busy0, done0;
    logic out1, busy1, done1;

    reset_pulse_generator #(.HOLD_COUNT(H0), .GUARD_COUNT(G0), .ACTIVE_LOW(1'b1)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .req(req0),
        .out_rst(out0), .busy(busy0), .done(done0)
    );

    reset_pulse_generator #(.HOLD_COUNT(H1), .GUARD_COUNT(G1), .ACTIVE_LOW(1'b0)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .req(req1),
        .out_rst(out1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: a hold started at edge e asserts over edges [e, e+H), stays busy until
    // edge e+H+G, where it either chains (new e) or finishes with done.
    int cyc;
    bit m_act[2];
    int m_e[2];
    bit m_pend[2];
    bit e_as[2];
    bit e_done[2];
    int m_done_cnt[2];
    int d_done_cnt[2];
    int hold_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k]  = 1'b0;
            m_e[k]    = 0;
            m_pend[k] = 1'b0;
            e_as[k]   = 1'b0;
            e_done[k] = 1'b0;
        end
    endtask

    task automatic step(input int k, input bit r, input int h, input int g);
        e_done[k] = 1'b0;
        if (m_act[k]) begin
            if (cyc == m_e[k] + h + g) begin
                if (m_pend[k] || r) begin
                    m_e[k]    = cyc;
                    m_pend[k] = 1'b0;
                end else begin
                    m_act[k]  = 1'b0;
                    e_done[k] = 1'b1;
                    m_done_cnt[k]++;
                end
            end else if (r && cyc > m_e[k] + h) begin
                m_pend[k] = 1'b1;
            end
        end else if (r) begin
            m_act[k] = 1'b1;
            m_e[k]   = cyc;
        end
        e_as[k] = m_act[k] && (cyc < m_e[k] + h);
    endtask

    task automatic compare_all();
        chk("m0_out_rst", 32'(out0), 32'(!e_as[0]));
        chk("m0_busy",    32'(busy0), 32'(m_act[0]));
        chk("m0_done",    32'(done0), 32'(e_done[0]));
        chk("m1_out_rst", 32'(out1), 32'(e_as[1]));
        chk("m1_busy",    32'(busy1), 32'(m_act[1]));
        chk("m1_done",    32'(done1), 32'(e_done[1]));
        if (done0) d_done_cnt[0]++;
        if (done1) d_done_cnt[1]++;
        // Independent run-length view of the active-low pin
        if (!out0) hold_len++;
        else if (hold_len > 0) begin
            chk("hold_len", 32'(hold_len), 32'(H0));
            hold_len = 0;
        end
    endtask

    task automatic tick(input bit r0, input bit r1);
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        if (!rst) begin
            cyc++;
            step(0, r0, H0, G0);
            step(1, r1, H1, G1);
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        cyc = 0;
        hold_len = 0;
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        m_done_cnt = '{0, 0};
        d_done_cnt = '{0, 0};
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out0",  32'(out0), 32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_out1",  32'(out1), 32'd0);
        rst = 1'b0;

        repeat (5) tick(1'b0, 1'b0);

        // Single pulse: asserted for offsets 0..3, busy 0..6, done at 7
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 1'b0);
            chk("s1_out",  32'(out0), 32'(i >= 4));
            chk("s1_busy", 32'(busy0), 32'(i < 7));
            chk("s1_done", 32'(done0), 32'(i == 7));
        end

        // Request held during hold is ignored
        for (int i = 0; i < 10; i++) begin
            tick(i < 3, 1'b0);
            chk("s2_out",  32'(out0), 32'(i >= 4));
            chk("s2_busy", 32'(busy0), 32'(i < 7));
            chk("s2_done", 32'(done0), 32'(i == 7));
        end

        // Pending request inside guard (offset 5) and on the final guard edge (offset 7)
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                tick(i == 0 || i == (p == 0 ? 5 : 7), 1'b0);
                chk("s3_out",  32'(out0), 32'(!((i < 4) || (i >= 7 && i < 11))));
                chk("s3_busy", 32'(busy0), 32'(i < 14));
                chk("s3_done", 32'(done0), 32'(i == 14));
            end
        end

        // Request on the last hold edge is still ignored (state is HOLD there)
        for (int i = 0; i < 10; i++) begin
            tick(i == 0 || i == 4, 1'b0);
            chk("s3c_done", 32'(done0), 32'(i == 7));
        end

        // Minimum sizes, active-high polarity
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, i == 0);
            chk("s4_out",  32'(out1), 32'(i == 0));
            chk("s4_busy", 32'(busy1), 32'(i < 2));
            chk("s4_done", 32'(done1), 32'(i == 2));
        end

        // Asynchronous reset mid-hold
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("s5_out0",  32'(out0), 32'd1);
        chk("s5_busy0", 32'(busy0), 32'd0);
        chk("s5_done0", 32'(done0), 32'd0);
        chk("s5_out1",  32'(out1), 32'd0);
        hold_len = 0;
        @(posedge clk);
        @(negedge clk);
        chk("s5_held_done0", 32'(done0), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 1'b0);
            chk("s5_out",  32'(out0), 32'(i >= 4));
            chk("s5_done", 32'(done0), 32'(i == 7));
        end

        // Random stress
        for (int n = 0; n < 3000; n++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        repeat (20) tick(1'b0, 1'b0);
        chk("done_cnt0", 32'(d_done_cnt[0]), 32'(m_done_cnt[0]));
        chk("done_cnt1", 32'(d_done_cnt[1]), 32'(m_done_cnt[1]));
        chk("idle_end0", 32'(busy0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_pulse_generator.md
# reset_pulse_generator

Drives a reset line toward an external target device. A one-cycle request pulse, typically from the debounced reset path or the control logic, produces a clean, fixed-width reset assertion. A guard interval follows before the next assertion can start. It is the output-side counterpart of the reset input conditioning path and owns the pin timing seen by the target.

## Interface

- `HOLD_COUNT`, default 65_536: number of `sys_clk` cycles the output reset is asserted; legal range is ≥ 1.
- `GUARD_COUNT`, default 65_536: number of `sys_clk` cycles the output stays deasserted after a hold before the next hold may begin; legal range is ≥ 1.
- `ACTIVE_LOW`, default 1: output pin polarity. 1 means the asserted level is 0; 0 means the asserted level is 1.
- `sys_clk`, input, 1: the only clock.
- `sys_rst`, input, 1: asynchronous, active-high reset of this block.
- `req`, input, 1: reset request, sampled on the `sys_clk` rising edge and synchronous to `sys_clk`.
- `out_rst`, output, 1: registered reset line to the target, with polarity set by `ACTIVE_LOW`.
- `busy`, output, 1: high during HOLD and GUARD.
- `done`, output, 1: one-cycle pulse marking completion of a full hold plus guard sequence.

## Operation

- **States:**
  - IDLE: output deasserted, `busy` = 0.
  - HOLD: output asserted, `busy` = 1.
  - GUARD: output deasserted, `busy` = 1.
- **Counter:** one down-counter shared by HOLD and GUARD. Width is `$clog2(max(HOLD_COUNT, GUARD_COUNT))`, minimum 1 bit. It is loaded with `HOLD_COUNT-1` or `GUARD_COUNT-1` on state entry. It never wraps and never underflows: a state is left when the counter reads 0.
- **Transitions:**
  - IDLE with `req` = 1 goes to HOLD and loads `HOLD_COUNT-1`.
  - HOLD with counter = 0 goes to GUARD and loads `GUARD_COUNT-1`; otherwise the counter decrements.
  - GUARD with counter = 0:
    - If `pending` = 1, go to HOLD, load `HOLD_COUNT-1`, and clear `pending`.
    - Otherwise go to IDLE and pulse `done`.
  - GUARD with counter ≠ 0: decrement the counter.
- **Request handling:**
  - `req` in HOLD is ignored; an ongoing hold is never extended or restarted.
  - `req` in GUARD sets the 1-bit `pending` flag. Multiple requests in one GUARD collapse to one.
  - If `req` = 1 on the same edge where GUARD ends, it counts as pending and is served immediately.
  - `done` is not pulsed when GUARD chains directly into HOLD. It pulses only when returning to IDLE.
- **Polarity:** `out_rst` is `~asserted` when `ACTIVE_LOW` = 1, else `asserted`. It is driven straight from a register with no combinational path from `req`.
- **Reset (`sys_rst` = 1, asynchronous):**
  - State goes to IDLE; counter and `pending` clear.
  - `busy` = 0 and `done` = 0.
  - `out_rst` goes to the deasserted level (1 if `ACTIVE_LOW`, else 0).
  - Asserting `sys_rst` mid-HOLD drops the target reset immediately, with no minimum-width guarantee.
  - After `sys_rst` is released, the first `req` is accepted on the first rising edge.

## Timing

- `req` = 1 sampled at edge E: from E onward, `out_rst` is asserted and `busy` = 1. Latency is 1 edge.
- `out_rst` stays asserted for exactly `HOLD_COUNT` cycles and deasserts at edge E+`HOLD_COUNT`.
- GUARD occupies edges E+`HOLD_COUNT` through E+`HOLD_COUNT`+`GUARD_COUNT`. At the last of these, `busy` falls and `done` = 1 for exactly one cycle.
- Minimum request-to-request spacing that yields two separate `done` pulses is `HOLD_COUNT`+`GUARD_COUNT`+1 cycles.
- A chained second hold begins at edge E+`HOLD_COUNT`+`GUARD_COUNT`. `busy` stays high continuously and the deassert gap is exactly `GUARD_COUNT` cycles.

## Test plan

1. Single pulse: `HOLD_COUNT`=4, `GUARD_COUNT`=3, `ACTIVE_LOW`=1, one-cycle `req` at edge 10.
   - `out_rst` = 0 across edges 10–13, = 1 from edge 14.
   - `busy` is high across edges 10–16.
   - `done` = 1 only after edge 17.
2. Ignored request: same setup, with `req` held high for edges 10–12 (during HOLD).
   - Exactly one 4-cycle hold, then one `done` pulse.
3. Pending and collision:
   - A `req` at edge 15 (inside GUARD) produces a second hold starting at edge 17, with no `done` between the two holds.
   - Repeating with `req` exactly at edge 17 gives the same result.
4. Polarity and minimum sizes: `ACTIVE_LOW`=0, `HOLD_COUNT`=1, `GUARD_COUNT`=1, `req` at edge 5.
   - `out_rst` = 1 for one cycle only.
   - `done` is high after edge 7.
5. Reset mid-HOLD: assert `sys_rst` between edges 11 and 12 of scenario 1.
   - `out_rst` returns to 1 immediately, `busy` = 0, no `done`.
   - A `req` after release produces a full 4-cycle hold.
6. Back-to-back stress: 1000 random `req` pulses.
   - Every hold is exactly `HOLD_COUNT` cycles and every gap is at least `GUARD_COUNT` cycles.
   - The `done` count equals the number of IDLE returns.
